// File: rtl/serial_twos_complement.sv
// Bit-serial two's-complement negator: emits -x LSB first using the
// "copy up to and including the first 1, then invert" rule, then presents the parallel result.
module serial_twos_complement #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_valid,
  output logic             ser_bit,
  output logic             ser_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-2:0] res;
  logic [WIDTH-1:0] res_shift;
  logic [CNT_W-1:0] cnt;
  logic             seen_one;
  logic             load;
  logic             last_bit;
  logic             neg_bit;

  function automatic logic neg_bit_f(input logic seen, input logic lsb);
    return seen ? ~lsb : lsb;
  endfunction

  assign load      = in_valid & in_ready;
  assign last_bit  = (cnt == CNT_LAST);
  assign neg_bit   = neg_bit_f(seen_one, opnd[0]);
  assign res_shift = {neg_bit, res};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = in_valid ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_bit   = 1'b0;
    ser_last  = 1'b0;
    case (state)
      IDLE:  in_ready = 1'b1;
      SHIFT: begin
        ser_valid = 1'b1;
        ser_bit   = neg_bit;
        ser_last  = last_bit;
      end
      HOLD:  in_ready = out_ready;
      default: ;
    endcase
  end

  // Serial stage: operand drains LSB first, result fills from the MSB side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd     <= '0;
      res      <= '0;
      cnt      <= '0;
      seen_one <= 1'b0;
    end else if (load) begin
      opnd     <= in_data;
      cnt      <= '0;
      seen_one <= 1'b0;
    end else if (state == SHIFT) begin
      opnd     <= opnd >> 1;
      res      <= res_shift[WIDTH-1:1];
      cnt      <= cnt + 1'b1;
      seen_one <= seen_one | opnd[0];
    end
  end

  // Result stage: overflow means no 1 below the MSB and the MSB itself is 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (state == SHIFT && last_bit) begin
      out_valid <= 1'b1;
      out_data  <= res_shift;
      out_ovf   <= ~seen_one & opnd[0];
    end else if (state == HOLD && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_twos_complement.sv
// Directed bench for serial_twos_complement at WIDTH=4: vector table plus
// hand-written backpressure, back-to-back and mid-operation reset sequences.
module tb_serial_twos_complement;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       ser_valid;
  logic       ser_bit;
  logic       ser_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_ovf;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] op;
    logic [3:0] res;
    logic       ovf;
  } vec_t;

  vec_t vecs[7];

  serial_twos_complement #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ser_valid (ser_valid),
    .ser_bit   (ser_bit),
    .ser_last  (ser_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts from IDLE, one phase after a rising edge; leaves the block in IDLE.
  task automatic run_op(input logic [3:0] op, input logic [3:0] exp_res, input logic exp_ovf);
    in_valid = 1'b1;
    in_data  = op;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    in_data  = ~op;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ser_valid", ser_valid, 1);
      check("ser_bit", ser_bit, exp_res[i]);
      check("ser_last", ser_last, (i == 3));
      check("shift_in_ready", in_ready, 0);
      check("shift_out_valid", out_valid, 0);
      step();
    end
    @(negedge clk);
    check("hold_out_valid", out_valid, 1);
    check("hold_out_data", out_data, exp_res);
    check("hold_out_ovf", out_ovf, exp_ovf);
    check("hold_ser_valid", ser_valid, 0);
    check("hold_ser_bit", ser_bit, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    check("retained_out_data", out_data, exp_res);
    check("retained_out_ovf", out_ovf, exp_ovf);
    step();
  endtask

  logic [3:0] b2b_ops[3];
  logic [3:0] b2b_res[3];
  int         acc_cyc[3];
  int         n_acc;
  int         n_res;
  logic       hs;

  initial begin
    vecs[0] = '{op: 4'b0101, res: 4'b1011, ovf: 1'b0};
    vecs[1] = '{op: 4'b0000, res: 4'b0000, ovf: 1'b0};
    vecs[2] = '{op: 4'b1111, res: 4'b0001, ovf: 1'b0};
    vecs[3] = '{op: 4'b1000, res: 4'b1000, ovf: 1'b1};
    vecs[4] = '{op: 4'b0111, res: 4'b1001, ovf: 1'b0};
    vecs[5] = '{op: 4'b0001, res: 4'b1111, ovf: 1'b0};
    vecs[6] = '{op: 4'b0110, res: 4'b1010, ovf: 1'b0};
    b2b_ops = '{4'b0001, 4'b0010, 4'b0011};
    b2b_res = '{4'b1111, 4'b1110, 4'b1101};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_ser_valid", ser_valid, 0);
    check("rst_ser_last", ser_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    step();
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 7; v++)
      run_op(vecs[v].op, vecs[v].res, vecs[v].ovf);

    // Backpressure in HOLD with a new operand waiting
    in_valid = 1'b1;
    in_data  = 4'b0011;
    step();
    in_data  = 4'b0101;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, 4'b1101);
      check("bp_in_ready", in_ready, 0);
      check("bp_ser_valid", ser_valid, 0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 4'b1111;
    @(negedge clk);
    check("bp_new_ser_valid", ser_valid, 1);
    check("bp_new_ser_bit0", ser_bit, 1);
    check("bp_new_out_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    check("bp_new_out_data", out_data, 4'b1011);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();

    // Back-to-back operands with downstream always ready
    n_acc     = 0;
    n_res     = 0;
    in_valid  = 1'b1;
    in_data   = b2b_ops[0];
    out_ready = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      hs = in_valid & in_ready;
      if (out_valid && n_res < 3) begin
        check("b2b_result", out_data, b2b_res[n_res]);
        n_res++;
      end
      step();
      if (hs && n_acc < 3) begin
        acc_cyc[n_acc] = c;
        n_acc++;
        if (n_acc == 3) in_valid = 1'b0;
        else            in_data  = b2b_ops[n_acc];
      end
    end
    out_ready = 1'b0;
    check("b2b_accepts", n_acc, 3);
    check("b2b_results", n_res, 3);
    check("b2b_gap01", acc_cyc[1] - acc_cyc[0], 5);
    check("b2b_gap12", acc_cyc[2] - acc_cyc[1], 5);
    step();

    // Leave a retained overflow result, then reset mid-SHIFT
    run_op(4'b1000, 4'b1000, 1'b1);
    in_valid = 1'b1;
    in_data  = 4'b0110;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_seq_bit0", ser_bit, 0);
    step();
    @(negedge clk);
    check("rst_seq_bit1", ser_bit, 1);
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_ser_valid", ser_valid, 0);
    check("mid_rst_ser_bit", ser_bit, 0);
    check("mid_rst_ser_last", ser_last, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_ovf", out_ovf, 0);
    check("mid_rst_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", out_valid, 0);
      step();
    end
    run_op(4'b0110, 4'b1010, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
